// File: rtl/vlogic_pipe_if.sv
// Handshake and data bundle for vlogic_pipe: command, source-beat and result-beat channels.
// The master drives commands and source beats; the slave (the pipe) returns result beats.
interface vlogic_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int VL_WIDTH   = 8
);
  logic                          start_i;
  logic [2:0]                    op_i;
  logic [VL_WIDTH-1:0]           vl_i;
  logic                          vm_i;
  logic                          busy_o;
  logic                          src_valid_i;
  logic                          src_ready_o;
  logic [LANES*DATA_WIDTH-1:0]   a_i;
  logic [LANES*DATA_WIDTH-1:0]   b_i;
  logic [LANES-1:0]              mask_i;
  logic                          res_valid_o;
  logic                          res_ready_i;
  logic [LANES*DATA_WIDTH-1:0]   res_o;
  logic [LANES-1:0]              res_be_o;
  logic                          res_last_o;
  logic                          done_o;

  modport master (
    output start_i, op_i, vl_i, vm_i, src_valid_i, a_i, b_i, mask_i, res_ready_i,
    input  busy_o, src_ready_o, res_valid_o, res_o, res_be_o, res_last_o, done_o
  );

  modport slave (
    input  start_i, op_i, vl_i, vm_i, src_valid_i, a_i, b_i, mask_i, res_ready_i,
    output busy_o, src_ready_o, res_valid_o, res_o, res_be_o, res_last_o, done_o
  );
endinterface

// File: rtl/vlogic_pipe.sv
// Vector bitwise-logic pipe: LANES elements per beat, 1-cycle latency, 1 beat/cycle.
// Source is stalled only while a result is held un-accepted; vl=0 completes with no beats.
module vlogic_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int VL_WIDTH   = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  vlogic_pipe_if.slave bus
);
  localparam int CW = VL_WIDTH + 1;
  localparam int BW = LANES * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [VL_WIDTH-1:0] vl_q, vl_d;
  logic                vm_q, vm_d;
  logic                res_vld_q, res_vld_d;
  logic [BW-1:0]       res_q, res_d;
  logic [LANES-1:0]    be_q, be_d;
  logic                last_q, last_d;
  logic                done_q, done_d;

  logic                  src_rdy, src_acc, res_acc, beat_last, start_idle;
  logic [BW-1:0]         beat_res;
  logic [LANES-1:0]      beat_be;
  logic [DATA_WIDTH-1:0] lane_a, lane_b, lane_r;

  assign start_idle = (state_q == S_IDLE) && bus.start_i;
  assign src_rdy    = (state_q == S_RUN) && (!res_vld_q || bus.res_ready_i);
  assign src_acc    = src_rdy && bus.src_valid_i;
  assign res_acc    = res_vld_q && bus.res_ready_i;
  // One extra bit of headroom so cnt+LANES cannot wrap in the compare.
  assign beat_last  = ({1'b0, cnt_q} + (CW+1)'(LANES)) >= {2'b00, vl_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
      be_q      <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      vl_q      <= vl_d;
      vm_q      <= vm_d;
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
      be_q      <= be_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_idle && (bus.vl_i != '0)) state_d = S_RUN;
      S_RUN:   if (src_acc && beat_last)           state_d = S_DRAIN;
      S_DRAIN: if (res_acc && last_q)              state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    beat_res = '0;
    beat_be  = '0;
    lane_a   = '0;
    lane_b   = '0;
    lane_r   = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_a = bus.a_i[k*DATA_WIDTH +: DATA_WIDTH];
      lane_b = bus.b_i[k*DATA_WIDTH +: DATA_WIDTH];
      case (op_q)
        3'b000: lane_r = lane_a & lane_b;
        3'b001: lane_r = lane_a | lane_b;
        3'b010: lane_r = lane_a ^ lane_b;
        3'b011: lane_r = ~(lane_a & lane_b);
        3'b100: lane_r = ~lane_a & lane_b;
        3'b101: lane_r = ~(lane_a | lane_b);
        3'b110: lane_r = ~lane_a | lane_b;
        default: lane_r = ~(lane_a ^ lane_b);
      endcase
      if ((({1'b0, cnt_q} + (CW+1)'(k)) < {2'b00, vl_q}) && (vm_q || bus.mask_i[k])) begin
        beat_be[k] = 1'b1;
        beat_res[k*DATA_WIDTH +: DATA_WIDTH] = lane_r;
      end
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    vl_d      = vl_q;
    vm_d      = vm_q;
    res_vld_d = res_vld_q;
    res_d     = res_q;
    be_d      = be_q;
    last_d    = last_q;
    done_d    = 1'b0;
    if (start_idle) begin
      if (bus.vl_i != '0) begin
        op_d  = bus.op_i;
        vl_d  = bus.vl_i;
        vm_d  = bus.vm_i;
        cnt_d = '0;
      end else begin
        done_d = 1'b1;
      end
    end
    // A new beat overwrites the output stage in the same cycle it drains.
    if (src_acc) begin
      cnt_d     = cnt_q + CW'(LANES);
      res_vld_d = 1'b1;
      res_d     = beat_res;
      be_d      = beat_be;
      last_d    = beat_last;
    end else if (res_acc) begin
      res_vld_d = 1'b0;
      last_d    = 1'b0;
    end
  end

  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.src_ready_o = src_rdy;
  assign bus.res_valid_o = res_vld_q;
  assign bus.res_o       = res_q;
  assign bus.res_be_o    = be_q;
  assign bus.res_last_o  = last_q;
  assign bus.done_o      = done_q || ((state_q == S_DRAIN) && res_acc && last_q);
endmodule

// File: tb/tb_vlogic_pipe.sv
// Scoreboard bench for vlogic_pipe: expected beats queued at source acceptance, compared at result handshake.
module tb_vlogic_pipe;
  localparam int DW = 32;
  localparam int LN = 4;
  localparam int VW = 8;
  localparam int BW = DW * LN;

  typedef struct packed {
    logic [BW-1:0] res;
    logic [LN-1:0] be;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vlogic_pipe_if #(.DATA_WIDTH(DW), .LANES(LN), .VL_WIDTH(VW)) bus ();

  vlogic_pipe #(.DATA_WIDTH(DW), .LANES(LN), .VL_WIDTH(VW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  beat_t exp_q[$];
  int n_chk = 0, n_pass = 0, n_push = 0, n_pop = 0, done_cnt = 0;
  int rdy_mode = 1;
  logic [2:0]    m_op;
  logic [VW-1:0] m_vl;
  logic          m_vm;
  int            m_cnt;
  logic [BW-1:0] last_obs_res;
  logic [LN-1:0] last_obs_be;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp_v);
  endtask

  function automatic logic [DW-1:0] lfn(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~a & b;
      3'd5: return ~(a | b);
      3'd6: return ~a | b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic beat_t model(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [LN-1:0] mask);
    beat_t r;
    r = '0;
    for (int k = 0; k < LN; k++) begin
      if ((m_cnt + k < int'(m_vl)) && (m_vm || mask[k])) begin
        r.be[k] = 1'b1;
        r.res[k*DW +: DW] = lfn(m_op, a[k*DW +: DW], b[k*DW +: DW]);
      end
    end
    r.last = (m_cnt + LN >= int'(m_vl));
    return r;
  endfunction

  // Downstream ready: 0 = stall, 1 = always ready, 2 = random.
  initial begin
    bus.res_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.res_ready_i = 1'b0;
        1: bus.res_ready_i = 1'b1;
        default: bus.res_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (bus.done_o) done_cnt++;
      if (!rst && bus.res_valid_o && bus.res_ready_i) begin
        check("sb_nonempty", BW'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_pop++;
          check("res", bus.res_o, e.res);
          check("be", BW'(bus.res_be_o), BW'(e.be));
          check("last", BW'(bus.res_last_o), BW'(e.last));
          if (e.last) check("done_at_last", BW'(bus.done_o), 1);
          last_obs_res = bus.res_o;
          last_obs_be  = bus.res_be_o;
        end
      end
    end
  end

  task automatic start_op(input logic [2:0] op, input logic [VW-1:0] vl, input logic vm);
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.vl_i    = vl;
    bus.vm_i    = vm;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    m_op  = op;
    m_vl  = vl;
    m_vm  = vm;
    m_cnt = 0;
  endtask

  task automatic send_beat(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [LN-1:0] mask);
    int t = 0;
    bit ok = 1'b0;
    bus.src_valid_i = 1'b1;
    bus.a_i    = a;
    bus.b_i    = b;
    bus.mask_i = mask;
    while (!ok && t < 100) begin
      @(negedge clk);
      if (bus.src_ready_o) begin
        exp_q.push_back(model(a, b, mask));
        m_cnt += LN;
        n_push++;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      t++;
    end
    bus.src_valid_i = 1'b0;
    check("src_accept", BW'(ok), 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bus.busy_o || exp_q.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("idle", {bus.busy_o, exp_q.size() == 0}, 2'b01);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [VW-1:0] vl, input logic vm,
                        input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [LN-1:0] mask,
                        input bit rnd);
    int nb;
    logic [BW-1:0] ra, rb;
    logic [LN-1:0] rm;
    nb = (int'(vl) + LN - 1) / LN;
    start_op(op, vl, vm);
    for (int i = 0; i < nb; i++) begin
      ra = rnd ? {$urandom, $urandom, $urandom, $urandom} : a;
      rb = rnd ? {$urandom, $urandom, $urandom, $urandom} : b;
      rm = rnd ? LN'($urandom) : mask;
      send_beat(ra, rb, rm);
    end
    wait_idle();
  endtask

  initial begin
    int dc;
    logic [BW-1:0] held;
    logic [LN-1:0] held_be;
    bus.start_i = 1'b0; bus.op_i = '0; bus.vl_i = '0; bus.vm_i = 1'b0;
    bus.src_valid_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.mask_i = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", BW'(bus.busy_o), 0);
    check("rst_src_rdy", BW'(bus.src_ready_o), 0);
    check("rst_res_vld", BW'(bus.res_valid_o), 0);
    check("rst_last", BW'(bus.res_last_o), 0);
    check("rst_done", BW'(bus.done_o), 0);
    check("rst_res", bus.res_o, 0);
    check("rst_be", BW'(bus.res_be_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // AND across 8 elements; a start while busy must not disturb the running op.
    dc = done_cnt;
    start_op(3'b000, 8'd8, 1'b1);
    check("t1_busy", BW'(bus.busy_o), 1);
    bus.start_i = 1'b1; bus.op_i = 3'b111; bus.vl_i = 8'd1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    for (int i = 0; i < 2; i++) send_beat({4{32'hFFFF0000}}, {4{32'h0F0F0F0F}}, 4'h0);
    wait_idle();
    check("t1_res", last_obs_res, {4{32'h0F0F0000}});
    check("t1_be", BW'(last_obs_be), BW'(4'b1111));
    check("t1_done_cnt", done_cnt - dc, 1);

    // XNOR with partial tail beat.
    run_op(3'b111, 8'd6, 1'b1, {4{32'h12345678}}, {4{32'h12345678}}, 4'h0, 1'b0);
    check("t2_res", last_obs_res, {32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF});
    check("t2_be", BW'(last_obs_be), BW'(4'b0011));

    // Masked ANDN.
    run_op(3'b100, 8'd4, 1'b0, '0, {4{32'hAAAAAAAA}}, 4'b1010, 1'b0);
    check("t3_res", last_obs_res, {32'hAAAAAAAA, 32'h0, 32'hAAAAAAAA, 32'h0});
    check("t3_be", BW'(last_obs_be), BW'(4'b1010));

    // Backpressure: output held for three stalled cycles.
    rdy_mode = 0;
    start_op(3'b010, 8'd12, 1'b1);
    send_beat({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 4'h0);
    @(negedge clk);
    held    = bus.res_o;
    held_be = bus.res_be_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_src_rdy", BW'(bus.src_ready_o), 0);
      check("bp_vld", BW'(bus.res_valid_o), 1);
      check("bp_res_stable", bus.res_o, held);
      check("bp_be_stable", BW'(bus.res_be_o), BW'(held_be));
    end
    @(posedge clk);
    #1;
    rdy_mode = 1;
    for (int i = 0; i < 2; i++)
      send_beat({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 4'h0);
    wait_idle();
    check("bp_counts", n_pop, n_push);

    // Zero-length operation.
    dc = done_cnt;
    bus.start_i = 1'b1; bus.op_i = 3'b000; bus.vl_i = 8'd0;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("vl0_done", BW'(bus.done_o), 1);
    check("vl0_busy", BW'(bus.busy_o), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("vl0_quiet", BW'({bus.res_valid_o, bus.done_o}), 0);
    end
    check("vl0_done_cnt", done_cnt - dc, 1);
    @(posedge clk);
    #1;

    // Reset in the middle of an operation.
    rdy_mode = 0;
    start_op(3'b001, 8'd16, 1'b1);
    send_beat({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 4'h0);
    @(negedge clk);
    check("mid_vld", BW'(bus.res_valid_o), 1);
    dc = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ctl", BW'({bus.busy_o, bus.src_ready_o, bus.res_valid_o, bus.res_last_o, bus.done_o}), 0);
    check("mid_rst_res", bus.res_o, 0);
    check("mid_rst_be", BW'(bus.res_be_o), 0);
    exp_q.delete();
    n_pop = 0;
    n_push = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    check("mid_no_done", done_cnt - dc, 0);
    check("mid_idle", BW'(bus.busy_o), 0);
    @(posedge clk);
    #1;
    run_op(3'b101, 8'd9, 1'b1, '0, '0, '0, 1'b1);
    check("post_rst_done", done_cnt - dc, 1);

    // Every op under random data, masks and downstream throttling.
    rdy_mode = 2;
    for (int op = 0; op < 8; op++)
      run_op(3'(op), VW'($urandom_range(1, 20)), 1'($urandom_range(0, 1)), '0, '0, '0, 1'b1);
    rdy_mode = 1;
    check("sb_counts", n_pop, n_push);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
